// File: rtl/comparador_serial_di.sv
// Bit-serial magnitude comparator: one time-shared comparison cell walks the
// operands LSB-first, so the final (MSB) bit decides A<B or A<=B.
module comparador_serial_di #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_le,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             n;
    logic [CW-1:0]    cnt;
    logic             n_next;

    // Equal bits pass the carry, a differing bit overrides it.
    assign n_next = (n & (~sa[0] | sb[0])) | (~sa[0] & sb[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sa     <= '0;
            sb     <= '0;
            n      <= 1'b0;
            cnt    <= '0;
            result <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        n      <= mode_le;
                        cnt    <= '0;
                        result <= 1'b0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    n   <= n_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result <= n_next;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_comparador_serial_di.sv
// Randomized bench for comparador_serial_di against an arithmetic a<b / a<=b model.
module tb_comparador_serial_di;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mode_le = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic             result;

    int n_cmp = 0;
    int n_err = 0;

    comparador_serial_di #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_le(mode_le),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic model(input int unsigned x, input int unsigned y, input logic le);
        return le ? (x <= y) : (x < y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE: check latency, pulse width, result and latching.
    task automatic run_cmp(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic le);
        int  lat;
        logic exp;
        exp     = model(xa, xb, le);
        a       = xa;
        b       = xb;
        mode_le = le;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        a       = WIDTH'($urandom);
        b       = WIDTH'($urandom);
        mode_le = 1'($urandom);
        chk("busy_after_start", busy, 1);
        lat = -1;
        for (int i = 1; i <= WIDTH + 3; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, WIDTH);
        chk("result", result, exp);
        chk("busy_in_done", busy, 0);
        tick();
        chk("done_width", done, 0);
        chk("result_hold", result, exp);
    endtask

    initial begin
        int busy_cnt, done_cnt, done_at, lat;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        #12 rst = 1'b0;
        tick();

        run_cmp(8'h05, 8'h09, 1'b0);
        run_cmp(8'h09, 8'h05, 1'b0);
        run_cmp(8'h3C, 8'h3C, 1'b0);
        run_cmp(8'h3C, 8'h3C, 1'b1);
        run_cmp(8'h00, 8'hFF, 1'b0);
        run_cmp(8'hFF, 8'h00, 1'b0);
        run_cmp(8'h80, 8'h7F, 1'b0);

        // Held start: busy 8 cycles, single done, re-accept 10 edges later.
        a = 8'h01; b = 8'h02; mode_le = 1'b0; start = 1'b1;
        tick();
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 1; i <= WIDTH + 1; i++) begin
            tick();
            if (i == 3) a = 8'hFF;
            if (i <= WIDTH + 0 && busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
                chk("hold_result", result, 1);
            end
        end
        chk("hold_busy_cycles", busy_cnt, WIDTH);
        chk("hold_done_count", done_cnt, 1);
        chk("hold_done_at", done_at, WIDTH);
        chk("hold_idle_busy", busy, 0);
        tick();
        chk("hold_reaccept", busy, 1);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= WIDTH + 3; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        chk("hold2_latency", lat, WIDTH);
        chk("hold2_result", result, model(8'hFF, 8'h02, 1'b0));
        tick();

        // Reset in the middle of a run.
        a = 8'h01; b = 8'h02; mode_le = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        chk("post_rst_quiet", done_cnt, 0);
        run_cmp(8'h10, 8'h20, 1'b0);

        // Random sweep per mode.
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 1000; k++)
                run_cmp(WIDTH'($urandom), WIDTH'($urandom), 1'(m));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/comparador_serial_di.md
# comparador_serial_di

Bit-serial magnitude-comparison controller built around one right-to-left comparison cell, where `N = n&(~A|B) | (~A&B)`. It latches two WIDTH-bit operands on a start request and feeds them LSB-first through that single cell, one bit per clock. The carry `n` is held in a flip-flop between bits. After WIDTH cycles it reports `A<B` (or `A<=B`) with a start/busy/done handshake. It replaces a WIDTH-long combinational chain of cells with one time-shared cell.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥ 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a comparison; sampled only in IDLE.
- `mode_le` input 1: 0 selects `A<B`, 1 selects `A<=B`; sampled with `start`.
- `a` input WIDTH: operand A; sampled with `start`.
- `b` input WIDTH: operand B; sampled with `start`.
- `busy` output 1: high while bits are being processed (RUN).
- `done` output 1: one-cycle pulse when `result` becomes valid.
- `result` output 1: comparison result; held until the next accepted `start`.

## Operation
- Internal registers:
  - `sa`, `sb`: WIDTH-bit shift registers.
  - `n`: cell carry flip-flop.
  - `cnt`: bit counter, `$clog2(WIDTH)` bits wide.
  - `state`: IDLE, RUN or DONE.
- Cell function per bit, with `a0=sa[0]` and `b0=sb[0]`: `N = n&(~a0|b0) | (~a0&b0)`.
  - Equal bits propagate `n`.
  - `a0<b0` forces 1.
  - `a0>b0` forces 0.
  - The last processed bit (the MSB) dominates.
- IDLE:
  - `busy=0`, `done=0`.
  - On `start=1`: `sa<=a`, `sb<=b`, `n<=mode_le`, `cnt<=0`, `result<=0`, then go to RUN.
- RUN:
  - `busy=1`.
  - Each edge: `n<=N`, `sa<=sa>>1`, `sb<=sb>>1`, `cnt<=cnt+1`.
  - On the edge where `cnt==WIDTH-1`: `result<=N`, go to DONE.
- DONE:
  - `done=1`, `busy=0`.
  - Next edge returns to IDLE unconditionally.
- `start` is ignored in RUN and DONE; it is not queued.
- Changes on `a`, `b` or `mode_le` after acceptance have no effect on the comparison in progress.
- `result` stays stable from DONE until the next accepted `start`, which clears it to 0.
- Reset, asynchronous at any time including mid-RUN:
  - state IDLE; `busy=0`, `done=0`, `result=0`.
  - `n=0`, `cnt=0`, `sa=0`, `sb=0`.
  - Any partial comparison is discarded and no `done` is produced.
- Release of `rst` takes effect at the next rising edge; `start` is sampled from the first edge after release.

## Timing
- Edge E0 samples `start=1` in IDLE.
- `busy` is high from after E0 through E(WIDTH).
- `done` and `result` are valid in the cycle after edge E(WIDTH). Latency from the start edge to `done` is WIDTH edges.
- `done` is exactly one cycle wide; the block is back in IDLE after E(WIDTH+1).
- Back-to-back throughput is one comparison per WIDTH+2 cycles: a new `start` can first be accepted at E(WIDTH+2).
- Combinational paths: none from inputs to outputs; all outputs are registered or decoded from `state`.

## Test plan
- WIDTH=8, `mode_le=0`:
  - `a=0x05`, `b=0x09` -> `done` 8 edges after start, `result=1`.
  - `a=0x09`, `b=0x05` -> `result=0`.
- Equality, `a=b=0x3C`:
  - `mode_le=0` -> `result=0`.
  - `mode_le=1` -> `result=1`.
- Extremes, `mode_le=0`:
  - `a=0x00`, `b=0xFF` -> `result=1`.
  - `a=0xFF`, `b=0x00` -> `result=0`.
  - `a=0x80`, `b=0x7F` -> `result=0` (MSB dominates the lower bits).
- Handshake:
  - Hold `start=1` continuously with `a=0x01`, `b=0x02`; change `a` to 0xFF mid-RUN.
  - Required: `result=1`, `done` a single-cycle pulse, `busy` high for exactly 8 cycles.
  - Next acceptance occurs 10 edges after the first.
- Reset mid-run:
  - Assert `rst` asynchronously at cnt=4.
  - Required: `busy`, `done`, `result` go to 0 immediately, with no `done` afterwards.
  - A new start with `a=0x10`, `b=0x20` gives `result=1` after 8 edges.
- Randomized sweep of 1000 operand pairs per mode against a reference `a<b` / `a<=b` model, with an exact-latency check on every transaction.
